// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: opcodes and signed clamp helper shared by the vector ALU pipeline
package vector_alu_pkg;
  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_XOR  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_INC  = 3'b111
  } alu_op_t;
  // Clamps a sign-extended wide value into the signed range of a w-bit lane (w <= 32).
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    return v > mx ? mx : v < mn ? mn : v;
  endfunction
endpackage

// File: rtl/vector_alu_lane.sv
// alu_lane: combinational single-lane ALU with optional signed saturation and flags
module alu_lane
  import vector_alu_pkg::*;
#(
  parameter int dataSize = 8
) (
  input  logic [2:0]          op,
  input  logic                saturate,
  input  logic [dataSize-1:0] a,
  input  logic [dataSize-1:0] b,
  output logic [dataSize-1:0] result,
  output logic                neg,
  output logic                zero
);
  alu_op_t o;
  logic signed [63:0] ea, eb, wide, clamped;
  logic [dataSize-1:0] arith;
  assign o = alu_op_t'(op);
  // Arithmetic runs on sign-extended operands so the same sum feeds both wrap and clamp paths.
  always_comb begin
    ea = {{(64-dataSize){a[dataSize-1]}}, a};
    eb = {{(64-dataSize){b[dataSize-1]}}, b};
    wide = o == OP_ADD ? ea + eb : o == OP_SUB ? ea - eb : o == OP_MUL ? ea * eb : ea + 64'sd1;
    clamped = sat_clamp(wide, dataSize);
    arith = saturate ? clamped[dataSize-1:0] : wide[dataSize-1:0];
    result = o == OP_PASS ? a : o == OP_XOR ? a ^ b : o == OP_SHR ? a >> b : o == OP_SHL ? a << b : arith;
  end
  assign neg  = result[dataSize-1];
  assign zero = result == '0;
endmodule

// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: two-stage valid/ready pipelined multi-lane ALU
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int dataSize = 8,
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                operation_select,
  input  logic                      saturate,
  input  logic [LANES*dataSize-1:0] operand1,
  input  logic [LANES*dataSize-1:0] operand2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*dataSize-1:0] result,
  output logic [LANES-1:0]          neg_flag,
  output logic [LANES-1:0]          zero_flag,
  output logic                      all_zero
);
  localparam int W = LANES * dataSize;
  logic s1_valid, s2_valid, s1_sat, s2_adv;
  logic [2:0] s1_op;
  logic [W-1:0] s1_a, s1_b, lane_res;
  logic [LANES-1:0] lane_neg, lane_zero;
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_lane #(.dataSize(dataSize)) u_lane (
      .op(s1_op),
      .saturate(s1_sat),
      .a(s1_a[i*dataSize +: dataSize]),
      .b(s1_b[i*dataSize +: dataSize]),
      .result(lane_res[i*dataSize +: dataSize]),
      .neg(lane_neg[i]),
      .zero(lane_zero[i])
    );
  end
  // S1 operand capture; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_op  <= operation_select;
      s1_sat <= saturate;
      s1_a   <= operand1;
      s1_b   <= operand2;
    end
  end
  // Stage valids and S2 result; S2 only loads real transactions so outputs hold through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      result    <= '0;
      neg_flag  <= '0;
      zero_flag <= '0;
      all_zero  <= 1'b1;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        result    <= lane_res;
        neg_flag  <= lane_neg;
        zero_flag <= lane_zero;
        all_zero  <= &lane_zero;
      end
    end
  end
endmodule
